// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//
// Shares one single-port SRAM between two requesters: the host (UART side)
// and the SoC core. Each access walks IDLE -> ISSUE -> (CAPTURE) -> DONE.
// The SRAM is selected only in ISSUE. Read data is taken from the SRAM in
// CAPTURE, which is the cycle after the select. The requester sees a
// one-cycle ack in DONE.
//
// Optional feature (macro SRAM_ARB_ROUND_ROBIN_EN):
//   defined     - when both sides request together, the side not granted
//                 last wins. A last-grant pointer is kept for this.
//   undefined   - when both sides request together, the host always wins.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   host_req/we/addr/wdata/wmask -> host_ack, host_rdata   host command/response
//   soc_req/we/addr/wdata/wmask  -> soc_ack,  soc_rdata    SoC command/response
//   host_lock                blocks SoC grants while high
//   sram_csb_n, sram_we_n, sram_addr, sram_din, sram_wmask, sram_dout
//                            single-port SRAM, active-low select/write enable
//   busy                     high whenever the FSM is not idle

module sram_port_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                host_req,
    input  logic                host_we,
    input  logic [ADDR_W-1:0]   host_addr,
    input  logic [DATA_W-1:0]   host_wdata,
    input  logic [DATA_W/8-1:0] host_wmask,
    output logic                host_ack,
    output logic [DATA_W-1:0]   host_rdata,

    input  logic                soc_req,
    input  logic                soc_we,
    input  logic [ADDR_W-1:0]   soc_addr,
    input  logic [DATA_W-1:0]   soc_wdata,
    input  logic [DATA_W/8-1:0] soc_wmask,
    output logic                soc_ack,
    output logic [DATA_W-1:0]   soc_rdata,

    input  logic                host_lock,

    output logic                sram_csb_n,
    output logic                sram_we_n,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_din,
    output logic [DATA_W/8-1:0] sram_wmask,
    input  logic [DATA_W-1:0]   sram_dout,

    output logic                busy
);

    localparam int MASK_W = DATA_W / 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic GRANT_HOST = 1'b0;
    localparam logic GRANT_SOC  = 1'b1;

    logic [1:0]        state_q, state_d;
    logic              grant_q, grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic [DATA_W-1:0] soc_rdata_q, soc_rdata_d;

    logic soc_eligible;
    logic any_req;
    logic pick_soc;
    logic issue;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
`endif

    // host_lock only gates the IDLE sample, so raising it never aborts an
    // access that is already running.
    assign soc_eligible = soc_req && !host_lock;
    assign any_req      = host_req || soc_eligible;

    // Winner selection. This result is used only when the FSM samples in IDLE.
    always_comb begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        if (host_req && soc_eligible) begin
            pick_soc = (last_q == GRANT_HOST);
        end else begin
            pick_soc = soc_eligible;
        end
`else
        pick_soc = soc_eligible && !host_req;
`endif
    end

    // Next-state logic. The command is latched at grant time so that the
    // SRAM drive in ISSUE depends only on registered values.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        host_rdata_d = host_rdata_q;
        soc_rdata_d  = soc_rdata_q;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        last_d       = last_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d = pick_soc ? GRANT_SOC : GRANT_HOST;
                    we_d    = pick_soc ? soc_we    : host_we;
                    addr_d  = pick_soc ? soc_addr  : host_addr;
                    wdata_d = pick_soc ? soc_wdata : host_wdata;
                    wmask_d = pick_soc ? soc_wmask : host_wmask;
                    state_d = ST_ISSUE;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                    last_d  = pick_soc ? GRANT_SOC : GRANT_HOST;
`endif
                end
            end
            ST_ISSUE: begin
                state_d = we_q ? ST_DONE : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // The SRAM output is valid one cycle after the select.
                if (grant_q == GRANT_SOC) begin
                    soc_rdata_d = sram_dout;
                end else begin
                    host_rdata_d = sram_dout;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers. The last-grant pointer resets to SOC so that the
    // first contested grant goes to the host.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= GRANT_HOST;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            host_rdata_q <= '0;
            soc_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            host_rdata_q <= host_rdata_d;
            soc_rdata_q  <= soc_rdata_d;
        end
    end

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= GRANT_SOC;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // SRAM drive: idle values (deselected, all zero) in every state except
    // ISSUE, so a reset mid-access deselects the SRAM at once.
    assign issue      = (state_q == ST_ISSUE);
    assign sram_csb_n = !issue;
    assign sram_we_n  = issue ? !we_q : 1'b1;
    assign sram_addr  = issue ? addr_q  : '0;
    assign sram_din   = issue ? wdata_q : '0;
    assign sram_wmask = issue ? wmask_q : '0;

    assign host_ack   = (state_q == ST_DONE) && (grant_q == GRANT_HOST);
    assign soc_ack    = (state_q == ST_DONE) && (grant_q == GRANT_SOC);
    assign host_rdata = host_rdata_q;
    assign soc_rdata  = soc_rdata_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, meaning SRAM word-address width (32 words).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning SRAM word width; byte mask width is DATA_W/8.
REQ-003 Port clk  in  1  The single clock; all state updates on its rising edge.
REQ-004 Port rst  in  1  Reset, asynchronous and active-high.
REQ-005 Ports host_req/host_we  in  1 each  Host (UART side) access request and write select.
REQ-006 Ports host_addr in ADDR_W, host_wdata in DATA_W, host_wmask in DATA_W/8  Host command.
REQ-007 Ports host_ack out 1, host_rdata out DATA_W  Host completion pulse and read data.
REQ-008 Ports soc_req, soc_we, soc_addr, soc_wdata, soc_wmask, soc_ack, soc_rdata  Same set, widths and directions for the SoC core side.
REQ-009 Port host_lock  in  1  When high, SoC requests are never granted.
REQ-010 Ports sram_csb_n out 1, sram_we_n out 1, sram_addr out ADDR_W, sram_din out DATA_W, sram_wmask out DATA_W/8, sram_dout in DATA_W  Single-port SRAM, active-low select and write enable.
REQ-011 Port busy  out  1  High in every state other than IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, ISSUE, CAPTURE and DONE.
REQ-013 In IDLE with an eligible request, the block SHALL latch the winner's we/addr/wdata/wmask and grant id, then go to ISSUE; with no eligible request it SHALL stay in IDLE.
REQ-014 In ISSUE, sram_csb_n SHALL be 0 and sram_we_n SHALL equal the inverted latched we, with addr/din/wmask driven from the latched command; the next state SHALL be CAPTURE for reads and DONE for writes.
REQ-015 In CAPTURE, sram_dout SHALL be registered into the granted side's rdata register; the next state SHALL be DONE.
REQ-016 In DONE, only the granted side's ack SHALL be high for exactly one cycle; the next state SHALL be IDLE.
REQ-017 Latency from request sampled in IDLE at cycle T SHALL be: write ack at T+2, read ack at T+3 with rdata valid from T+3 and held until that side's next read completes.
REQ-018 Requesters SHALL hold req and command stable until ack; the block SHALL sample req only in IDLE, so a req still high during DONE starts a new access at the following IDLE.
REQ-019 Outside ISSUE, sram_csb_n and sram_we_n SHALL be 1 and sram_addr/din/wmask SHALL be 0.
REQ-020 A write with wmask 0 SHALL still perform the ISSUE cycle and ack normally.
REQ-021 soc_req is eligible only when host_lock is 0; host_lock changes take effect at the next IDLE sample, never aborting an access in progress.
REQ-022 host_req is always eligible.

Reset
REQ-023 When rst is high, the state SHALL be IDLE and outputs SHALL be: sram_csb_n=1, sram_we_n=1, sram_addr/din/wmask=0, host_ack=soc_ack=0, host_rdata=soc_rdata=0, busy=0.
REQ-024 Reset asserted mid-access SHALL abort it with no ack issued; the SRAM is not selected after rst asserts.
REQ-025 The last-grant pointer SHALL reset to SOC.

Configuration
REQ-026 Macro SRAM_ARB_ROUND_ROBIN_EN: when defined, simultaneous eligible requests in IDLE SHALL grant the side not granted last, and the pointer updates on every grant.
REQ-027 When SRAM_ARB_ROUND_ROBIN_EN is not defined, simultaneous eligible requests SHALL always grant host; the pointer is absent.

Verification
REQ-028 Host write addr 5, data 0xDEADBEEF, mask 0xF, then host read addr 5 -> write ack at T+2, read ack at T+3, host_rdata=0xDEADBEEF.
REQ-029 Host and SoC reads requested in the same cycle from reset -> host acked first, SoC acked 4 cycles later; with macro and both held high, grants then alternate host/SoC; without macro, host always wins.
REQ-030 host_lock=1, soc_req held high for 10 cycles -> no soc_ack and no SRAM select; lower host_lock -> SoC read acks 3 cycles after the next IDLE sample.
REQ-031 SoC write addr 31, data 0x12345678, mask 0x3 -> in ISSUE sram_wmask=0x3, sram_we_n=0, sram_addr=31; soc_ack at T+2, host_ack stays 0.
REQ-032 Assert rst during CAPTURE of a host read -> sram_csb_n=1, host_ack never pulses, host_rdata=0, busy=0 after reset; the next request completes normally.
